// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box tables, byte-matrix type, round constants,
// and the GF(2^8) helpers used by the key schedule and the inverse round.
package aes_pkg;

   localparam int NUM_ROUNDS  = 10;
   localparam int KEY_SCHED_W = 128 * (NUM_ROUNDS + 1);

   // Column-major view of a 128-bit block: [column][row], byte 0 at [0][0].
   typedef logic [7:0] byte_matrix_t [4][4];

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   localparam logic [79:0] RCON = 80'h01020408102040801b36;
   // InvMixColumns row 0 coefficients 0e,0b,0d,09; later rows are rotations.
   localparam logic [15:0] INV_MIX_COEF = 16'hebd9;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] wd);
      return {sbox(wd[31:24]), sbox(wd[23:16]), sbox(wd[15:8]), sbox(wd[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int i = 0; i < 4; i++) begin
         if (k[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [31:0] res;
      res = '0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            res[31-8*r -: 8] = res[31-8*r -: 8] ^
               gmul(col[31-8*k -: 8], INV_MIX_COEF[15-4*((k-r+4)%4) -: 4]);
      return res;
   endfunction

endpackage

// File: rtl/aes_inv_cipher_lib.sv
// Reused building blocks: KeyExpansion, AddRoundKey, binary_to_bcd, seven_seg.
module KeyExpansion
   import aes_pkg::*;
(
   input  logic [127:0]           key,
   output logic [KEY_SCHED_W-1:0] w
);
   logic [31:0] words [4*(NUM_ROUNDS+1)];
   logic [31:0] temp;

   // Round key r lands in w[128r +: 128] with its first word in the top 32 bits.
   always_comb begin
      words = '{default: '0};
      temp  = '0;
      w     = '0;
      for (int i = 0; i < 4*(NUM_ROUNDS+1); i++) begin
         if (i < 4) begin
            words[i] = key[127-32*i -: 32];
         end else begin
            temp = words[i-1];
            if (i % 4 == 0)
               temp = sub_word({temp[23:0], temp[31:24]}) ^ {RCON[87-8*(i/4) -: 8], 24'h0};
            words[i] = words[i-4] ^ temp;
         end
         w[128*(i/4) + 32*(3-i%4) +: 32] = words[i];
      end
   end
endmodule

module AddRoundKey (
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   output logic [127:0] out
);
   assign out = state ^ round_key;
endmodule

module binary_to_bcd (
   input  logic [7:0]  bin,
   output logic [11:0] bcd
);
   always_comb begin
      bcd = '0;
      for (int i = 7; i >= 0; i--) begin
         if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
         if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
         bcd = {bcd[10:0], bin[i]};
      end
   end
endmodule

module seven_seg (
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   // Active-high segments ordered gfedcba.
   always_comb begin
      seg = 7'h00;
      case (digit)
         4'd0: seg = 7'h3f;
         4'd1: seg = 7'h06;
         4'd2: seg = 7'h5b;
         4'd3: seg = 7'h4f;
         4'd4: seg = 7'h66;
         4'd5: seg = 7'h6d;
         4'd6: seg = 7'h7d;
         4'd7: seg = 7'h07;
         4'd8: seg = 7'h7f;
         4'd9: seg = 7'h6f;
         default: seg = 7'h00;
      endcase
   end
endmodule

// File: rtl/aes_inv_cipher_round.sv
// One inverse-cipher round; final_round skips InvMixColumns for the last step.
module DecryptionRound
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] next_state
);
   byte_matrix_t cur;
   byte_matrix_t shifted;
   logic [127:0] subbed, keyed, mixed;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         localparam int C = gi / 4;
         localparam int R = gi % 4;
         assign cur[C][R]     = state[127-8*gi -: 8];
         // Row R rotates right by R columns to undo ShiftRows.
         assign shifted[C][R] = cur[(C-R+4)%4][R];
         assign subbed[127-8*gi -: 8] = inv_sbox(shifted[C][R]);
      end
      for (gi = 0; gi < 4; gi++) begin : g_col
         assign mixed[127-32*gi -: 32] = inv_mix_column(keyed[127-32*gi -: 32]);
      end
   endgenerate

   AddRoundKey u_ark (.state(subbed), .round_key(round_key), .out(keyed));

   assign next_state = final_round ? keyed : mixed;
endmodule

// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher, one round per clock: 11 edges from accepted start to out_valid.
// Define AES_DEC_SEG_EN to add seg_out, a decimal 7-segment view of out[7:0].
module aes_inv_cipher
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] in,
   input  logic [127:0] Key,
   output logic         in_ready,
   output logic         out_valid,
   output logic [127:0] out
`ifdef AES_DEC_SEG_EN
   ,
   output logic [20:0]  seg_out
`endif
);
   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

   fsm_t                   fsm_reg, fsm_next;
   logic [127:0]           state_reg, state_next;
   logic [127:0]           key_reg, key_next;
   logic [3:0]             round_reg, round_next;
   logic                   accepting;
   logic [127:0]           sched_key, round_key, load_state, round_state;
   logic [KEY_SCHED_W-1:0] w;

   assign accepting = (fsm_reg == IDLE) || (fsm_reg == DONE);
   // The load cycle expands the live Key, since key_reg is only written on that same edge.
   assign sched_key = accepting ? Key : key_reg;
   assign round_key = w[128*int'(round_reg) +: 128];

   KeyExpansion u_key_exp (.key(sched_key), .w(w));

   AddRoundKey u_load (
      .state     (in),
      .round_key (w[128*NUM_ROUNDS +: 128]),
      .out       (load_state)
   );

   DecryptionRound u_round (
      .state       (state_reg),
      .round_key   (round_key),
      .final_round (fsm_reg == FINAL),
      .next_state  (round_state)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_reg   <= IDLE;
         state_reg <= '0;
         key_reg   <= '0;
         round_reg <= '0;
      end else begin
         fsm_reg   <= fsm_next;
         state_reg <= state_next;
         key_reg   <= key_next;
         round_reg <= round_next;
      end
   end

   always_comb begin
      fsm_next   = fsm_reg;
      state_next = state_reg;
      key_next   = key_reg;
      round_next = round_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (fsm_reg)
         IDLE, DONE: begin
            in_ready  = 1'b1;
            out_valid = (fsm_reg == DONE);
            if (start) begin
               key_next   = Key;
               state_next = load_state;
               round_next = 4'(NUM_ROUNDS - 1);
               fsm_next   = ROUND;
            end
         end
         ROUND: begin
            state_next = round_state;
            round_next = round_reg - 4'd1;
            if (round_reg == 4'd1) fsm_next = FINAL;
         end
         FINAL: begin
            state_next = round_state;
            fsm_next   = DONE;
         end
         default: fsm_next = IDLE;
      endcase
   end

   assign out = state_reg;

`ifdef AES_DEC_SEG_EN
   logic [11:0] bcd;

   binary_to_bcd u_bcd (.bin(out[7:0]), .bcd(bcd));

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit
         seven_seg u_seg (.digit(bcd[4*gi +: 4]), .seg(seg_out[7*gi +: 7]));
      end
   endgenerate
`endif
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher using FIPS-197 / SP 800-38A known-answer vectors.
module tb_aes_inv_cipher;
   logic         clk = 1'b0;
   logic         reset, start;
   logic [127:0] in, Key, out;
   logic         in_ready, out_valid;
`ifdef AES_DEC_SEG_EN
   logic [20:0]  seg_out;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [127:0] exp_q[$];

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

   aes_inv_cipher dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in        (in),
      .Key       (Key),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out       (out)
`ifdef AES_DEC_SEG_EN
      ,
      .seg_out   (seg_out)
`endif
   );

   always #5 clk = ~clk;

   // Called at a falling edge; returns one falling edge after the accepting edge.
   task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
      Key   = k;
      in    = c;
      start = 1'b1;
      exp_q.push_back(p);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts rising edges since acceptance until out_valid is seen, bounded.
   task automatic wait_done(input int from, output int cycles);
      cycles = from;
      while (out_valid !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   function automatic logic [127:0] pop_expected();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; in = '0; Key = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (out !== 128'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", in_ready); end
      $display("txn reset: out=%h in_ready=%b", out, in_ready);
   endtask

   task automatic test_vector(input string name, input logic [127:0] k,
                              input logic [127:0] c, input logic [127:0] p);
      int cyc;
      logic [127:0] exp;
      issue(k, c, p);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_busy: in_ready got %b want 0", name, in_ready); end
      wait_done(1, cyc);
      exp = pop_expected();
      n_checks++; if (cyc != 11) begin n_fail++; $display("FAIL %s_latency: got %0d edges want 11", name, cyc); end
      n_checks++; if (out !== exp) begin n_fail++; $display("FAIL %s_out: got %h want %h", name, out, exp); end
      $display("txn %s: out=%h edges=%0d", name, out, cyc);
   endtask

   task automatic test_hold();
      in = {$urandom, $urandom, $urandom, $urandom};
      Key = {$urandom, $urandom, $urandom, $urandom};
      repeat (5) @(negedge clk);
      n_checks++; if (out !== P1) begin n_fail++; $display("FAIL hold_out: got %h want %h", out, P1); end
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_flags: valid=%b ready=%b want 1 1", out_valid, in_ready); end
`ifdef AES_DEC_SEG_EN
      begin
         logic [20:0] seg_exp;
         seg_exp = {7'h5b, 7'h6d, 7'h6d};
         n_checks++; if (seg_out !== seg_exp) begin n_fail++; $display("FAIL seg_255: got %h want %h", seg_out, seg_exp); end
      end
`endif
      $display("txn hold: out=%h valid=%b", out, out_valid);
   endtask

   task automatic test_start_ignored();
      int cyc;
      logic [127:0] exp;
      issue(K1, C1, P1);
      repeat (2) @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ignored_ready: got %b want 0", in_ready); end
      Key = K2; in = C2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(4, cyc);
      exp = pop_expected();
      n_checks++; if (cyc != 11) begin n_fail++; $display("FAIL ignored_latency: got %0d edges want 11", cyc); end
      n_checks++; if (out !== exp) begin n_fail++; $display("FAIL ignored_out: got %h want %h", out, exp); end
      $display("txn start_ignored: out=%h edges=%0d", out, cyc);
   endtask

   task automatic test_reset_mid();
      issue(K2, C2, P2);
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      exp_q.delete();
      n_checks++; if (out !== 128'h0) begin n_fail++; $display("FAIL midreset_out: got %h want 0", out); end
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL midreset_flags: valid=%b ready=%b want 0 1", out_valid, in_ready); end
      $display("txn reset_mid: out=%h", out);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_vector("after_reset", K1, C1, P1);
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [127:0] exp;
      issue(K2, C2, P2);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: out_valid got %b want 0", out_valid); end
      wait_done(1, cyc);
      exp = pop_expected();
      n_checks++; if (cyc != 11) begin n_fail++; $display("FAIL b2b_latency: got %0d edges want 11", cyc); end
      n_checks++; if (out !== exp) begin n_fail++; $display("FAIL b2b_out: got %h want %h", out, exp); end
      $display("txn back_to_back: out=%h edges=%0d", out, cyc);
   endtask

   initial begin
      test_reset();
      test_vector("fips_c1", K1, C1, P1);
      test_hold();
      test_vector("fips_b", K2, C2, P2);
      test_vector("zero_key", 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0);
      test_vector("sp800_ecb", K2, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                  128'h6bc1bee22e409f96e93d7e117393172a);
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
- REQ-001: clk, input, 1, single clock; all state updates on rising edge.
- REQ-002: reset, input, 1, asynchronous active-high reset.
- REQ-003: start, input, 1, request to decrypt in/Key; accepted only when in_ready=1.
- REQ-004: in, input, 128, ciphertext block, MSB = byte 0 (FIPS-197 order).
- REQ-005: Key, input, 128, AES-128 cipher key, sampled with start.
- REQ-006: in_ready, output, 1, high in IDLE and DONE.
- REQ-007: out_valid, output, 1, high in DONE only.
- REQ-008: out, output, 128, plaintext block; valid only while out_valid=1.
- REQ-009: seg_out, output, 21, three 7-segment digits of out[7:0] in decimal, hundreds at [20:14]; present only under AES_DEC_SEG_EN.

Function
- REQ-010: FSM states are IDLE, ROUND, FINAL and DONE.
- REQ-011: In IDLE or DONE, start=1 latches Key into key_reg, loads state <= in XOR w[10], sets round <= 9, and enters ROUND.
- REQ-012: In ROUND, each cycle state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), w[round])), round decrements, and the FSM enters FINAL after round=1.
- REQ-013: FINAL state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), w[0]), then DONE.
- REQ-014: Latency: out_valid rises exactly 11 clock edges after the accepting edge (1 load edge, 9 round edges, 1 final edge).
- REQ-015: The round-key schedule is KeyExpansion of key_reg, 1408 bits, where w[r] = bits [128r+127 : 128r].
- REQ-016: The load cycle uses KeyExpansion of the live Key input for w[10]; all later cycles use key_reg.
- REQ-017: start is ignored in ROUND and FINAL; in, Key and state are not disturbed mid-operation.
- REQ-018: out and out_valid hold in DONE indefinitely until the next accepted start.
- REQ-019: start in DONE is accepted back-to-back; out_valid drops the following cycle.
- REQ-020: out is driven from the state register only and is never combinational from in.
- REQ-021: round is a 4-bit counter; it never wraps below 1 in ROUND.

Reset
- REQ-022: Asserting reset at any time, including mid-decryption, forces IDLE, state=0, key_reg=0, round=0, out_valid=0, in_ready=1 and out=0 immediately.
- REQ-023: After reset deassertion, the first accepted start behaves as specified in REQ-011.

Configuration
- REQ-024: Macro AES_DEC_SEG_EN: when defined, seg_out exists and shows out[7:0] through binary_to_bcd and three seven_seg instances.
- REQ-025: When AES_DEC_SEG_EN is undefined, seg_out and its logic are absent.

Structure
- REQ-026: The shared package aes_pkg holds the S-box inverse table, state-to-byte-matrix typedef, round-count constant (10) and key-schedule width (1408).
- REQ-027: One sub-module, DecryptionRound, provides state, round key and a final flag as inputs and the next state as output (InvMixColumns bypassed when final=1).
- REQ-028: The existing KeyExpansion, AddRoundKey, binary_to_bcd and seven_seg modules are reused unchanged.

Verification
- REQ-029: Key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a, start 1 cycle -> out 00112233445566778899aabbccddeeff, out_valid after 11 edges.
- REQ-030: Key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734.
- REQ-031: start pulsed with different in/Key during ROUND -> ignored; result equals REQ-029 vector.
- REQ-032: reset asserted at round=5 -> out=0 and out_valid=0 immediately; a new start afterwards yields the correct plaintext.
- REQ-033: Back-to-back: start in the DONE cycle with the REQ-030 vector -> out_valid low 11 cycles, then REQ-030 plaintext.
- REQ-034: With AES_DEC_SEG_EN and out[7:0]=0xff -> seg_out shows digits 2,5,5.
